// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with built-in load-use hazard detection.
// Captures the decoded instruction from ID, presents it to EX one cycle later,
// inserts a bubble on a load-use hazard or a taken-branch flush, and drives
// the PC and IF/ID load enables. A saturating counter tallies load-use stalls.
//
// Upstream handshake: pcWrite/ifidWrite act as the "ready" of this stage
// towards IF/ID. When either is low in a cycle, the upstream registers must
// keep their contents so that the same instruction is offered again on the
// next cycle. There is no separate valid; a bubble is an all-zero bundle.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic [4:0]        IDRs,
  input  logic [4:0]        IDRt,
  input  logic [4:0]        IDRd,
  input  logic [DATA_W-1:0] IDdata1,
  input  logic [DATA_W-1:0] IDdata2,
  input  logic [DATA_W-1:0] IDimm,
  input  logic [CTRL_W-1:0] IDctrl,
  output logic [4:0]        EXRs,
  output logic [4:0]        EXRt,
  output logic [4:0]        EXRd,
  output logic [DATA_W-1:0] EXdata1,
  output logic [DATA_W-1:0] EXdata2,
  output logic [DATA_W-1:0] EXimm,
  output logic [CTRL_W-1:0] EXctrl,
  output logic              pcWrite,
  output logic              ifidWrite,
  output logic              stall,
  output logic [CNT_W-1:0]  stallCount
);

  // Position of memRead inside the control bundle.
  localparam int CTRL_MEM_READ = 1;

  // What the register does on the coming edge, in priority order.
  typedef enum logic [2:0] {
    ACT_RESET   = 3'd0,
    ACT_HOLD    = 3'd1,
    ACT_FLUSH   = 3'd2,
    ACT_BUBBLE  = 3'd3,
    ACT_CAPTURE = 3'd4
  } action_e;

  action_e action;
  logic    hazard;

  logic [4:0]        rs_q, rs_d;
  logic [4:0]        rt_q, rt_d;
  logic [4:0]        rd_q, rd_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic [DATA_W-1:0] data2_q, data2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Load in EX whose destination is read by the instruction in ID; $zero never counts.
  always_comb begin
    hazard = ctrl_q[CTRL_MEM_READ] & (rt_q != 5'd0) &
             ((rt_q == IDRs) | (rt_q == IDRt));
  end

  // Resolve the per-cycle priority: reset, hold, flush, hazard, then normal capture.
  always_comb begin
    action = ACT_CAPTURE;
    if (rst) begin
      action = ACT_RESET;
    end else if (hold) begin
      action = ACT_HOLD;
    end else if (flush) begin
      // The dependent instruction is squashed, so a coincident hazard is moot.
      action = ACT_FLUSH;
    end else if (hazard) begin
      action = ACT_BUBBLE;
    end
  end

  // Upstream enables and the stall flag, combinational from the current action.
  always_comb begin
    pcWrite   = 1'b1;
    ifidWrite = 1'b1;
    stall     = 1'b0;
    case (action)
      ACT_HOLD: begin
        pcWrite   = 1'b0;
        ifidWrite = 1'b0;
      end
      ACT_BUBBLE: begin
        pcWrite   = 1'b0;
        ifidWrite = 1'b0;
        stall     = 1'b1;
      end
      default: begin
        pcWrite   = 1'b1;
        ifidWrite = 1'b1;
        stall     = 1'b0;
      end
    endcase
  end

  // Next-state for the pipeline register and the stall counter.
  always_comb begin
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    data1_d = data1_q;
    data2_d = data2_q;
    imm_d   = imm_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    case (action)
      ACT_RESET: begin
        rs_d    = '0;
        rt_d    = '0;
        rd_d    = '0;
        data1_d = '0;
        data2_d = '0;
        imm_d   = '0;
        ctrl_d  = '0;
        cnt_d   = '0;
      end
      ACT_HOLD: begin
        // Everything keeps its value; defaults already say so.
      end
      ACT_FLUSH, ACT_BUBBLE: begin
        // Zero specifiers too, so the bubble never matches in forwarding.
        rs_d    = '0;
        rt_d    = '0;
        rd_d    = '0;
        data1_d = '0;
        data2_d = '0;
        imm_d   = '0;
        ctrl_d  = '0;
        if (action == ACT_BUBBLE && cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        rs_d    = IDRs;
        rt_d    = IDRt;
        rd_d    = IDRd;
        data1_d = IDdata1;
        data2_d = IDdata2;
        imm_d   = IDimm;
        ctrl_d  = IDctrl;
      end
    endcase
  end

  // State registers; reset is folded into the next-state logic above.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      data1_q <= '0;
      data2_q <= '0;
      imm_q   <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign EXRs       = rs_q;
  assign EXRt       = rt_q;
  assign EXRd       = rd_q;
  assign EXdata1    = data1_q;
  assign EXdata2    = data2_q;
  assign EXimm      = imm_q;
  assign EXctrl     = ctrl_q;
  assign stallCount = cnt_q;

endmodule
